// File: rtl/cnt_seg_pkg.sv
// rtl/cnt_seg_pkg.sv - shared types and constants for the counter display path
// Contents: FSM state encoding, active-low 7-segment codes (gfedcba),
// digit index constants and a BCD-to-segment encoder.
package cnt_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_OVF  = 2'd3;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 8-bit binary to 3-digit BCD (shift/add-3)
// Ports: clk, _areset (async, active-high), start (accepted in IDLE),
// bin[7:0] value to convert, busy (high from accept through LOAD),
// done (one-cycle pulse while in LOAD), hund/tens/ones BCD result.
module bin2bcd_seq
  import cnt_seg_pkg::*;
(
  input  logic       clk,
  input  logic       _areset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  state_e      state_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  logic [11:0] adj_d;
  logic [19:0] shift_d;

  // Correct each nibble before the shift so it never leaves the 0..9 range.
  always_comb begin
    adj_d = bcd_q;
    if (bcd_q[3:0]  >= 4'd5) adj_d[3:0]  = bcd_q[3:0]  + 4'd3;
    if (bcd_q[7:4]  >= 4'd5) adj_d[7:4]  = bcd_q[7:4]  + 4'd3;
    if (bcd_q[11:8] >= 4'd5) adj_d[11:8] = bcd_q[11:8] + 4'd3;
    shift_d = {adj_d, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge _areset) begin
    if (_areset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= shift_d[19:8];
          bin_q <= shift_d[7:0];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= LOAD;
            done_q  <= 1'b1;
          end
        end
        LOAD: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hund = bcd_q[11:8];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/cnt_seg_scan.sv
// rtl/cnt_seg_scan.sv - counter value capture, BCD conversion and 4-digit 7-seg scan
// Ports: clk, _areset (async, active-high), sample strobe, dcout[7:0] and
// overflow captured on an accepted sample, busy while converting,
// an[3:0] active-low digit enables (0=ones,1=tens,2=hundreds,3=overflow),
// seg[6:0] active-low {g,f,e,d,c,b,a}.
// Option macro: CNT_SEG_BLANK_LZ_EN blanks leading zeros on hundreds/tens.
module cnt_seg_scan
  import cnt_seg_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int DIV_W    = 10
) (
  input  logic       clk,
  input  logic       _areset,
  input  logic       sample,
  input  logic [7:0] dcout,
  input  logic       overflow,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic       conv_busy;
  logic       conv_done;
  logic [3:0] conv_hund;
  logic [3:0] conv_tens;
  logic [3:0] conv_ones;
  logic       start;

  // Strobes arriving mid-conversion are dropped, not queued.
  assign start = sample & ~conv_busy;

  bin2bcd_seq u_conv (
    .clk     (clk),
    ._areset (_areset),
    .start   (start),
    .bin     (dcout),
    .busy    (conv_busy),
    .done    (conv_done),
    .hund    (conv_hund),
    .tens    (conv_tens),
    .ones    (conv_ones)
  );

  logic             ov_q;
  logic [3:0]       hund_q;
  logic [3:0]       tens_q;
  logic [3:0]       ones_q;
  logic             ov_disp_q;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;

  always_comb begin
    presc_d = presc_q + DIV_W'(1);
    idx_d   = idx_q;
    if (presc_q == DIV_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end

    seg_d = SEG_BLANK;
    case (idx_q)
      DIG_ONES: seg_d = seg_encode(ones_q);
      DIG_TENS: begin
        seg_d = seg_encode(tens_q);
`ifdef CNT_SEG_BLANK_LZ_EN
        if (hund_q == 4'd0 && tens_q == 4'd0) seg_d = SEG_BLANK;
`endif
      end
      DIG_HUND: begin
        seg_d = seg_encode(hund_q);
`ifdef CNT_SEG_BLANK_LZ_EN
        if (hund_q == 4'd0) seg_d = SEG_BLANK;
`endif
      end
      DIG_OVF:  seg_d = ov_disp_q ? SEG_DASH : SEG_BLANK;
      default:  seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge _areset) begin
    if (_areset) begin
      ov_q      <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      ov_disp_q <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      if (start) ov_q <= overflow;
      // Display only changes once the full conversion is done.
      if (conv_done) begin
        hund_q    <= conv_hund;
        tens_q    <= conv_tens;
        ones_q    <= conv_ones;
        ov_disp_q <= ov_q;
      end
      presc_q <= presc_d;
      idx_q   <= idx_d;
      // an and seg come from the same index in the same cycle.
      an_q    <= ~(4'b0001 << idx_q);
      seg_q   <= seg_d;
    end
  end

  assign busy = conv_busy;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// tb/tb_cnt_seg_scan.sv - randomized self-checking bench for cnt_seg_scan
module tb_cnt_seg_scan;

  localparam int SCAN_DIV = 4;
  localparam int DIV_W    = 2;

  logic       clk      = 1'b0;
  logic       areset   = 1'b1;
  logic       sample   = 1'b0;
  logic [7:0] dcout    = 8'd0;
  logic       overflow = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  cnt_seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk      (clk),
    ._areset  (areset),
    .sample   (sample),
    .dcout    (dcout),
    .overflow (overflow),
    .busy     (busy),
    .an       (an),
    .seg      (seg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tbl [10];
  logic [3:0] an_tbl  [4];

  // Reference model: what is displayed, and the pending conversion.
  int m_edge;
  int m_val;
  bit m_ov;
  bit m_busy;
  int m_load_edge;
  int m_cap_val;
  bit m_cap_ov;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx);
    int v;
    v = m_val;
    case (idx)
      0: return seg_tbl[v % 10];
      1: begin
`ifdef CNT_SEG_BLANK_LZ_EN
        if (v < 10) return 7'b1111111;
`endif
        return seg_tbl[(v / 10) % 10];
      end
      2: begin
`ifdef CNT_SEG_BLANK_LZ_EN
        if (v < 100) return 7'b1111111;
`endif
        return seg_tbl[v / 100];
      end
      default: return m_ov ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Called at a falling edge; drives inputs, advances one clock, checks.
  task automatic step(input bit smp, input int val, input bit ov);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int         idx;
    sample   = smp;
    dcout    = val[7:0];
    overflow = ov;
    @(posedge clk);
    m_edge++;
    idx   = ((m_edge - 1) / SCAN_DIV) % 4;
    e_an  = an_tbl[idx];
    e_seg = exp_seg(idx);
    if (m_busy && m_edge == m_load_edge) begin
      m_val  = m_cap_val;
      m_ov   = m_cap_ov;
      m_busy = 1'b0;
    end else if (!m_busy && smp) begin
      m_cap_val   = val & 255;
      m_cap_ov    = ov;
      m_busy      = 1'b1;
      m_load_edge = m_edge + 9;
    end
    @(negedge clk);
    check_eq("an",   32'(an),   32'(e_an));
    check_eq("seg",  32'(seg),  32'(e_seg));
    check_eq("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  // Called at a falling edge; reset must take effect without a clock edge.
  task automatic do_reset(input int hold);
    sample = 1'b0;
    areset = 1'b1;
    #1;
    check_eq("rst_async_an",   32'(an),   32'hf);
    check_eq("rst_async_seg",  32'(seg),  32'h7f);
    check_eq("rst_async_busy", 32'(busy), 32'h0);
    repeat (hold) @(negedge clk);
    check_eq("rst_hold_an",  32'(an),  32'hf);
    check_eq("rst_hold_seg", 32'(seg), 32'h7f);
    areset      = 1'b0;
    m_edge      = 0;
    m_val       = 0;
    m_ov        = 1'b0;
    m_busy      = 1'b0;
    m_load_edge = -1;
    #1;
    check_eq("rst_rel_an", 32'(an), 32'hf);
  endtask

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    @(negedge clk);
    do_reset(2);
    idle(20);

    // Full-scale value, then overflow with zero value.
    step(1'b1, 255, 1'b0);
    idle(20);
    step(1'b1, 0, 1'b1);
    idle(20);

    // Second strobe four cycles into a conversion is ignored.
    step(1'b1, 123, 1'b0);
    idle(3);
    step(1'b1, 45, 1'b0);
    idle(20);

    // Back-to-back at the first legal cycle after completion.
    step(1'b1, 200, 1'b0);
    idle(9);
    step(1'b1, 9, 1'b0);
    idle(20);

    // Reset while scanning.
    idle(6);
    do_reset(3);
    idle(10);

    // Load a nonzero value, then reset at the 4th shift of the next conversion.
    step(1'b1, 77, 1'b1);
    idle(20);
    step(1'b1, 99, 1'b0);
    idle(4);
    do_reset(2);
    idle(20);

    // Randomized strobes, including ones that land while busy.
    for (int k = 0; k < 60; k++) begin
      idle(int'($urandom_range(0, 14)));
      step(1'b1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_seg_scan.md
Name: cnt_seg_scan

Overview:
- Downstream display stage for the 8-bit up/down counter.
- Captures the counter value (dcout) and overflow flag on a sample strobe.
- Converts the value to three decimal digits with a sequential shift-add-3 (double-dabble) converter.
- Time-multiplexes the digits, plus an overflow indicator digit, onto a 4-digit common-anode 7-segment display.

Parameters:
- SCAN_DIV, 1024: clk cycles each digit stays enabled; legal range ≥2.
- DIV_W, 10: prescaler width; must satisfy 2**DIV_W ≥ SCAN_DIV.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- _areset  input  1  reset, asynchronous, active-high; clears all state immediately.
- sample  input  1  capture strobe; accepted only when busy=0.
- dcout  input  8  counter value to display (unsigned 0..255).
- overflow  input  1  counter overflow flag, captured with dcout.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=overflow digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset values:
  - busy=0, an=4'b1111, seg=7'b1111111.
  - Display registers (hund/tens/ones) = 0; ov_disp = 0.
  - Prescaler = 0; digit index = 0; FSM = IDLE.
- Display after reset release: digits show "000", overflow digit blank. an begins scanning on the first clock after reset release.
- FSM states:
  - IDLE: on sample=1, latch dcout→bin_r and overflow→ov_r, clear BCD shift register, set bit counter=0, go to SHIFT, busy=1. With sample=0, stay in IDLE.
  - SHIFT: each cycle, add 3 to any BCD nibble ≥5, then shift {bcd,bin_r} left by 1 and increment the bit counter. After the 8th shift (counter=7), go to LOAD.
  - LOAD: copy the BCD nibbles into the display registers and ov_r into ov_disp, busy=0, go to IDLE.
- Latency:
  - Sample accepted at edge N.
  - Shifts occur at edges N+1..N+8.
  - Display registers update and busy falls at edge N+9.
  - A new sample can be accepted at edge N+10.
- Samples with busy=1 are ignored and not queued. dcout changes during conversion have no effect.
- Old display values remain shown until LOAD; no partial update is visible.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index increments mod 4 (3→0).
  - Scanning is independent of the FSM and runs continuously.
  - an = ~(4'b0001 << index), registered. seg is registered in the same cycle as an, so they are never misaligned.
- Segment codes (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Overflow digit: '-' = 0111111 when ov_disp=1, otherwise blank (1111111).
- BCD nibbles never exceed 9. Hundreds is at most 2.
- Reset mid-conversion: FSM returns to IDLE and all display state clears; no LOAD occurs.

Optional Feature:
- Macro: CNT_SEG_BLANK_LZ_EN.
- Defined: leading zeros are blanked.
  - Hundreds digit is blanked when 0.
  - Tens digit is blanked when hundreds=0 and tens=0.
  - Ones digit is always shown.
  - Example: value 7 displays "  7".
- Undefined: all three digits are always shown (value 7 displays "007").
- Blanking affects seg only; an still scans all four digits.

Decomposition:
- Shared package cnt_seg_pkg holds:
  - FSM state encodings: IDLE=2'd0, SHIFT=2'd1, LOAD=2'd2.
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - Digit index constants.
- Sub-module bin2bcd_seq holds the FSM plus the shift/add-3 datapath. Ports: clk, _areset, start, bin[7:0], busy, done, hund[3:0], tens[3:0], ones[3:0].
- Top level keeps the capture registers, display registers, prescaler, digit mux and segment encoder.

Test Plan:
- Reset: assert _areset mid-scan → an=1111, seg=1111111 and busy=0 immediately without a clock edge. After release with SCAN_DIV=4, an steps 1110→1101→1011→0111 every 4 cycles.
- Conversion: sample with dcout=8'd255, overflow=0 → busy high for 9 cycles. Display becomes 2/5/5 and seg for an[0] = 0010010. Overflow digit blank.
- Overflow: sample with dcout=8'd0, overflow=1 → digits 0/0/0 (feature off). an[3] active shows seg=0111111.
- Busy ignore: sample with dcout=123, then sample with dcout=45 four cycles later → display shows 1/2/3 only. busy falls exactly 9 cycles after the first sample.
- Back-to-back: samples 200, then 9 at the first legal cycle (N+10) → displays 2/0/0, then 0/0/9. With CNT_SEG_BLANK_LZ_EN, hundreds and tens for value 9 show 1111111.
- Reset mid-conversion: sample 99, assert _areset at the 4th shift → display 0/0/0, busy=0. No LOAD occurs after release.
